// File: rtl/ram_read_responder.sv
// Read-channel responder: turns a 32-bit word read into two 16-bit SRAM accesses
// (low half, then high half) under arbiter req/grant, returning the word with a one-cycle is_ready.
module ram_read_responder #(
    parameter int ADDR_W      = 19,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sig_read,
    input  logic [ADDR_W-1:0] address,
    output logic [31:0]       data,
    output logic              is_ready,
    output logic              busy,
    output logic              sram_req,
    input  logic              sram_grant,
    output logic [ADDR_W:0]   sram_addr,
    output logic              sram_oe_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    input  logic [15:0]       sram_dq_in
);

    typedef enum logic [2:0] {IDLE, REQ, ACCESS, DONE, RELEASE} state_t;
    typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} phase_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    typedef struct packed {
        state_t            state;
        phase_t            phase;
        logic [3:0]        cnt;
        logic [ADDR_W-1:0] addr_q;
        logic [15:0]       data_lo;
        logic [31:0]       data;
        logic              is_ready;
        logic              busy;
        logic              sram_req;
        logic              oe_n;
        logic [ADDR_W:0]   sram_addr;
    } regs_t;

    localparam regs_t RST = '{
        state:     IDLE,
        phase:     PH_LO,
        cnt:       CNT_INIT,
        addr_q:    '0,
        data_lo:   '0,
        data:      '0,
        is_ready:  1'b0,
        busy:      1'b0,
        sram_req:  1'b0,
        oe_n:      1'b1,
        sram_addr: '0
    };

    regs_t r, r_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r <= RST;
        else       r <= r_d;
    end

    always_comb begin
        r_d          = r;
        r_d.is_ready = 1'b0;

        case (r.state)
            IDLE: begin
                if (sig_read) begin
                    r_d.state  = REQ;
                    r_d.addr_q = address;
                    r_d.phase  = PH_LO;
                end
            end
            REQ: begin
                if (sram_grant) begin
                    r_d.state = ACCESS;
                    r_d.cnt   = CNT_INIT;
                end
            end
            ACCESS: begin
                // Losing the grant abandons only the half in flight; phase is kept.
                if (!sram_grant) begin
                    r_d.state = REQ;
                end else if (r.cnt == 4'd1) begin
                    if (r.phase == PH_LO) begin
                        r_d.data_lo = sram_dq_in;
                        r_d.phase   = PH_HI;
                        r_d.cnt     = CNT_INIT;
                    end else begin
                        r_d.data  = {sram_dq_in, r.data_lo};
                        r_d.state = DONE;
                    end
                end else begin
                    r_d.cnt = r.cnt - 4'd1;
                end
            end
            DONE: begin
                r_d.is_ready = 1'b1;
                r_d.state    = sig_read ? RELEASE : IDLE;
            end
            RELEASE: begin
                if (!sig_read) r_d.state = IDLE;
            end
            default: r_d.state = IDLE;
        endcase

        // SRAM-side outputs are registered from the state being entered.
        r_d.busy     = (r_d.state != IDLE);
        r_d.sram_req = (r_d.state == REQ) || (r_d.state == ACCESS);
        r_d.oe_n     = (r_d.state != ACCESS);
        if (r_d.state == ACCESS) r_d.sram_addr = {r_d.addr_q, r_d.phase};
    end

    assign data      = r.data;
    assign is_ready  = r.is_ready;
    assign busy      = r.busy;
    assign sram_req  = r.sram_req;
    assign sram_addr = r.sram_addr;
    assign sram_oe_n = r.oe_n;
    assign sram_ub_n = r.oe_n;
    assign sram_lb_n = r.oe_n;

endmodule

// File: doc/ram_read_responder.md
Name: ram_read_responder

Overview:
Server (responder) side of the RAM read channel. It accepts 32-bit word read requests from one client, such as the CPU instruction/data fetch port, and performs two 16-bit accesses on the shared SRAM: low half first, then high half. It returns the assembled word with a one-cycle is_ready pulse. SRAM ownership is obtained from the RAM arbiter through a req/grant pair, because the SRAM is shared with the write channels and video.

Parameters:
ADDR_W, 19, client word-address width; SRAM address width is ADDR_W+1.
WAIT_CYCLES, 2, cycles each half-access holds address/OE before sampling SRAM data (legal range 1..15).

Ports:
clk  in  1  system clock (50 MHz domain).
reset  in  1  asynchronous, active-high reset.
sig_read  in  1  client read request, level; held until is_ready seen.
address  in  ADDR_W  client 32-bit word address.
data  out  32  read data, valid when is_ready=1.
is_ready  out  1  one-cycle completion pulse.
busy  out  1  high in any state other than IDLE.
sram_req  out  1  request SRAM ownership from arbiter.
sram_grant  in  1  arbiter grant; SRAM pins are owned only while high.
sram_addr  out  ADDR_W+1  SRAM 16-bit word address.
sram_oe_n  out  1  SRAM output enable, active low.
sram_ub_n  out  1  upper byte enable, active low.
sram_lb_n  out  1  lower byte enable, active low.
sram_dq_in  in  16  SRAM data bus, read value.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; data=0; is_ready=0; busy=0; sram_req=0.
  - sram_oe_n=1, sram_ub_n=1, sram_lb_n=1; sram_addr=0; wait counter=WAIT_CYCLES.
- All outputs are registered.
- IDLE: sig_read=1 at an edge captures address into addr_q, sets phase=LOW, and goes to REQ.
  - address changes after capture are ignored.
- REQ: sram_req=1. On an edge with sram_grant=1, go to ACCESS and reload counter=WAIT_CYCLES.
- ACCESS:
  - sram_req=1; oe_n=0, ub_n=0, lb_n=0.
  - sram_addr = {addr_q,0} in phase LOW, {addr_q,1} in phase HIGH.
  - Counter decrements each edge. At the edge where counter==1, sram_dq_in is sampled:
    - phase LOW: sample into data_lo, set phase=HIGH, reload counter, stay in ACCESS.
    - phase HIGH: sample into data[31:16], copy data_lo into data[15:0], go to DONE.
- Grant loss: if sram_grant=0 at any edge in ACCESS, go to REQ.
  - oe_n/ub_n/lb_n go to 1.
  - The current phase is kept; the half in progress restarts with a full WAIT_CYCLES count when regranted.
  - A completed low half is not re-read.
- DONE: is_ready=1 for exactly one cycle; sram_req=0; oe_n=1. Next state is RELEASE if sig_read=1, else IDLE.
- RELEASE: waits until sig_read=0, then goes to IDLE. This prevents re-issuing the same request. Back-to-back reads therefore cost one extra cycle.
- Client dropping sig_read mid-access: the access still completes and is_ready still pulses, then the block goes to IDLE.
- data holds its last completed value until the next completion.
- Latency: for accept edge N with grant continuously high, is_ready is high in the cycle after edge N+2+2*WAIT_CYCLES. With the default, that is edge N+6.
- Address arithmetic: no wrap logic. The low half is at 2*addr_q and the high half at 2*addr_q+1, which never carries beyond ADDR_W+1 bits.

Test Plan:
- Reset mid-ACCESS (assert reset while oe_n=0) -> all outputs return to reset values immediately; next request runs normally from IDLE.
- Grant tied high; sig_read=1, address=0x00010; SRAM model returns 0xBEEF at 0x00020 and 0xDEAD at 0x00021 -> is_ready pulses 6 cycles after accept; data=0xDEADBEEF; sram_addr sequence 0x00020 (2 cycles), 0x00021 (2 cycles).
- Grant delayed 5 cycles after sram_req rises -> sram_oe_n stays 1 until grant; latency grows by exactly 5; data correct.
- Grant dropped for 3 cycles during the HIGH phase -> the low half is not re-read (sram_addr never returns to the even address); the high half restarts with a full 2-cycle wait; data correct.
- Client holds sig_read=1 for 4 cycles after is_ready -> exactly one SRAM transaction; busy stays 1 in RELEASE; a new request is accepted only after sig_read=0 then 1.
- Client drops sig_read during the LOW phase -> the access still completes, is_ready pulses once, and the next state is IDLE.
